// File: rtl/macc_drain.sv
// Snapshots the MACC array result bus, requantizes each lane from accumulator Q format to
// activation Q format (round-half-up, saturating) and streams lanes out one per valid/ready beat.
module macc_drain #(
    parameter  int NUM_PE = 16,
    parameter  int ACC_QM = 16,
    parameter  int ACC_QN = 16,
    parameter  int ACT_QM = 8,
    parameter  int ACT_QN = 8,
    localparam int ACC_BW = ACC_QM + ACC_QN,
    localparam int ACT_BW = ACT_QM + ACT_QN,
    localparam int IDX_BW = $clog2(NUM_PE + 1),
    localparam int SHIFT  = ACC_QN - ACT_QN
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cap_valid,
    output logic                           cap_ready,
    input  logic [1:0]                     cap_mode,
    input  logic [NUM_PE:0][ACC_BW-1:0]    din_acc,
    output logic                           dout_valid,
    input  logic                           dout_ready,
    output logic [ACT_BW-1:0]              dout_data,
    output logic [IDX_BW-1:0]              dout_idx,
    output logic                           dout_sat,
    output logic                           dout_last
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    localparam logic [IDX_BW-1:0] ACC_IDX = IDX_BW'(NUM_PE);
    localparam logic [IDX_BW-1:0] LAST_PE = IDX_BW'(NUM_PE - 1);

    // Half an output LSB in accumulator units; collapses to zero when no shift is needed.
    localparam logic signed [ACC_BW:0] RND     = ((ACC_BW+1)'(1) << SHIFT) >> 1;
    localparam logic signed [ACC_BW:0] SAT_MAX = ((ACC_BW+1)'(1) << (ACT_BW - 1)) - (ACC_BW+1)'(1);
    localparam logic signed [ACC_BW:0] SAT_MIN = ~SAT_MAX;

    // Returns {sat, data}; one extra bit of headroom keeps the rounding add from wrapping.
    function automatic logic [ACT_BW:0] requant(input logic [ACC_BW-1:0] lane);
        logic signed [ACC_BW:0] ext;
        logic signed [ACC_BW:0] rq;
        ext = $signed({lane[ACC_BW-1], lane});
        rq  = (ext + RND) >>> SHIFT;
        if (rq > SAT_MAX) begin
            requant = {1'b1, SAT_MAX[ACT_BW-1:0]};
        end else if (rq < SAT_MIN) begin
            requant = {1'b1, SAT_MIN[ACT_BW-1:0]};
        end else begin
            requant = {1'b0, rq[ACT_BW-1:0]};
        end
    endfunction

    logic [0:0]                    state_r;
    logic [IDX_BW-1:0]             end_idx_r;
    logic [NUM_PE:0][ACC_BW-1:0]   buf_r;

    logic                          cap_fire_s;
    logic                          adv_s;
    logic [IDX_BW-1:0]             start_idx_s;
    logic [IDX_BW-1:0]             end_idx_s;
    logic [IDX_BW-1:0]             nxt_idx_s;
    logic [ACC_BW-1:0]             nxt_lane_s;
    logic [ACT_BW:0]               rq_s;

    assign adv_s      = dout_valid & dout_ready;
    assign cap_ready  = (state_r == IDLE) | ((state_r == DRAIN) & adv_s & dout_last);
    assign cap_fire_s = cap_valid & cap_ready;

    // Mode decode and selection of the lane feeding the next output beat.
    always_comb begin
        start_idx_s = '0;
        end_idx_s   = ACC_IDX;
        nxt_idx_s   = dout_idx;
        nxt_lane_s  = buf_r[ACC_IDX];
        if (cap_mode == 2'b10) begin
            start_idx_s = ACC_IDX;
        end else begin
            start_idx_s = '0;
        end
        if (cap_mode == 2'b01) begin
            end_idx_s = LAST_PE;
        end else begin
            end_idx_s = ACC_IDX;
        end
        if (cap_fire_s) begin
            nxt_idx_s  = start_idx_s;
            nxt_lane_s = din_acc[start_idx_s];
        end else if (dout_idx < ACC_IDX) begin
            nxt_idx_s  = dout_idx + IDX_BW'(1);
            nxt_lane_s = buf_r[nxt_idx_s];
        end else begin
            nxt_idx_s  = ACC_IDX;
            nxt_lane_s = buf_r[ACC_IDX];
        end
    end

    assign rq_s = requant(nxt_lane_s);

    // Snapshot buffer; only written on an accepted capture, so pending beats are never disturbed.
    always_ff @(posedge clk) begin
        if (cap_fire_s) begin
            buf_r <= din_acc;
        end
    end

    // Control FSM and registered output beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            end_idx_r  <= ACC_IDX;
            dout_valid <= 1'b0;
            dout_data  <= '0;
            dout_idx   <= '0;
            dout_sat   <= 1'b0;
            dout_last  <= 1'b0;
        end else if (cap_fire_s) begin
            state_r    <= DRAIN;
            end_idx_r  <= end_idx_s;
            dout_valid <= 1'b1;
            dout_data  <= rq_s[ACT_BW-1:0];
            dout_idx   <= nxt_idx_s;
            dout_sat   <= rq_s[ACT_BW];
            dout_last  <= (nxt_idx_s == end_idx_s);
        end else if (adv_s && dout_last) begin
            state_r    <= IDLE;
            dout_valid <= 1'b0;
            dout_data  <= '0;
            dout_idx   <= '0;
            dout_sat   <= 1'b0;
            dout_last  <= 1'b0;
        end else if (adv_s) begin
            dout_data  <= rq_s[ACT_BW-1:0];
            dout_idx   <= nxt_idx_s;
            dout_sat   <= rq_s[ACT_BW];
            dout_last  <= (nxt_idx_s == end_idx_r);
        end
    end

endmodule
